// File: rtl/cc_regs_pkg.sv
// rtl/cc_regs_pkg.sv - shared defaults for the shadow register bank
//
// Purpose: default bus widths, default register count and the byte-count
// helper used by shadow_registers and shadow_register_cell.
// Ports: none (package).
package cc_regs_pkg;

  localparam int CC_ADDR_WIDTH = 8;
  localparam int CC_DATA_WIDTH = 16;
  localparam int CC_NUM_REGS   = 64;
  localparam int CC_NUM_BYTES  = CC_DATA_WIDTH / 8;

  // Number of byte lanes in a word of the given width.
  function automatic int bytes_of(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/shadow_register_cell.sv
// rtl/shadow_register_cell.sv - one staged register: shadow, live and dirty
//
// Purpose: holds the shadow (staged) word, the live (applied) word and the
// dirty flag for a single register.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   we          - write strobe for this register
//   be          - byte enables for the write
//   wdata       - write data
//   immediate   - register bypasses staging (live follows shadow on write)
//   commit      - copy shadow to live and clear dirty
//   shadow      - current shadow word
//   live        - current live word
//   dirty       - shadow holds data not yet committed
module shadow_register_cell
  import cc_regs_pkg::*;
#(
  parameter int DATA_WIDTH = CC_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    immediate,
  input  logic                    commit,
  output logic [DATA_WIDTH-1:0]   shadow,
  output logic [DATA_WIDTH-1:0]   live,
  output logic                    dirty
);

  localparam int NUM_BYTES = bytes_of(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] r_shadow;
  logic [DATA_WIDTH-1:0] r_live;
  logic                  r_dirty;
  logic [DATA_WIDTH-1:0] w_merged;

  always_comb begin
    w_merged = r_shadow;
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (be[k]) begin
        w_merged[8*k +: 8] = wdata[8*k +: 8];
      end
    end
  end

  // The write is applied after the commit so that a same-edge write and
  // commit publishes the old shadow and leaves the new data staged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow <= '0;
      r_live   <= '0;
      r_dirty  <= 1'b0;
    end else begin
      if (commit) begin
        r_live  <= r_shadow;
        r_dirty <= 1'b0;
      end
      if (we) begin
        r_shadow <= w_merged;
        if (immediate) begin
          r_live  <= w_merged;
          r_dirty <= 1'b0;
        end else begin
          r_dirty <= 1'b1;
        end
      end
    end
  end

  assign shadow = r_shadow;
  assign live   = r_live;
  assign dirty  = r_dirty;

endmodule

// File: rtl/shadow_registers.sv
// rtl/shadow_registers.sv - bank of frame-sync committed shadow registers
//
// Purpose: register bank where writes land in a shadow copy and become
// visible on values_out only after a commit strobe (unless the register is
// marked immediate).
// Ports:
//   clk, reset         - clock, asynchronous active-high reset
//   en, rd, wr         - access enable, read request, write request
//   be, addr, wdata    - byte enables, register address, write data
//   rdata, rvalid      - read data (0 when idle), one-cycle valid strobe
//   commit             - frame-sync commit strobe
//   commit_done        - one-cycle acknowledge after each commit
//   pending            - some register is staged but not committed
//   values_out         - all live words, register i at [DW*(i+1)-1:DW*i]
module shadow_registers
  import cc_regs_pkg::*;
#(
  parameter int                  ADDR_WIDTH     = CC_ADDR_WIDTH,
  parameter int                  DATA_WIDTH     = CC_DATA_WIDTH,
  parameter int                  NUM_REGS       = CC_NUM_REGS,
  parameter logic [NUM_REGS-1:0] IMMEDIATE_MASK = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic                           rd,
  input  logic                           wr,
  input  logic [DATA_WIDTH/8-1:0]        be,
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic [DATA_WIDTH-1:0]          wdata,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic                           rvalid,
  input  logic                           commit,
  output logic                           commit_done,
  output logic                           pending,
  output logic [DATA_WIDTH*NUM_REGS-1:0] values_out
);

  logic                  w_rd;
  logic                  w_wr;
  logic [NUM_REGS-1:0]   w_we;
  logic [NUM_REGS-1:0]   w_dirty;
  logic [DATA_WIDTH-1:0] w_shadow [NUM_REGS];
  logic [DATA_WIDTH-1:0] w_live   [NUM_REGS];
  logic [DATA_WIDTH-1:0] w_rd_data;

  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rvalid;
  logic                  r_commit_done;

  // A combined read+write is treated as a read only.
  assign w_rd = en & rd;
  assign w_wr = en & wr & ~rd;

  // Out-of-range addresses match no cell, so those writes simply vanish.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    assign w_we[i] = w_wr & (addr == ADDR_WIDTH'(i));

    shadow_register_cell #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_cell (
      .clk       (clk),
      .reset     (reset),
      .we        (w_we[i]),
      .be        (be),
      .wdata     (wdata),
      .immediate (IMMEDIATE_MASK[i]),
      .commit    (commit),
      .shadow    (w_shadow[i]),
      .live      (w_live[i]),
      .dirty     (w_dirty[i])
    );

    assign values_out[DATA_WIDTH*i +: DATA_WIDTH] = w_live[i];
  end

  // Read mux over shadow words; an unmatched address reads as 0.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr == ADDR_WIDTH'(i)) begin
        w_rd_data = w_shadow[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata       <= '0;
      r_rvalid      <= 1'b0;
      r_commit_done <= 1'b0;
    end else begin
      r_rvalid      <= w_rd;
      r_rdata       <= w_rd ? w_rd_data : '0;
      r_commit_done <= commit;
    end
  end

  assign rdata       = r_rdata;
  assign rvalid      = r_rvalid;
  assign commit_done = r_commit_done;
  assign pending     = |w_dirty;

endmodule

// File: tb/tb_shadow_registers.sv
// tb/tb_shadow_registers.sv - self-checking bench for shadow_registers
module tb_shadow_registers;

  localparam int AW = 5;
  localparam int DW = 16;
  localparam int NR = 16;
  localparam int NB = DW / 8;
  localparam logic [NR-1:0] IMM = 16'h0080;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            en = 1'b0, rd = 1'b0, wr = 1'b0, commit = 1'b0;
  logic [NB-1:0]   be = '0;
  logic [AW-1:0]   addr = '0;
  logic [DW-1:0]   wdata = '0;
  logic [DW-1:0]   rdata;
  logic            rvalid, commit_done, pending;
  logic [DW*NR-1:0] values_out;

  shadow_registers #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .NUM_REGS       (NR),
    .IMMEDIATE_MASK (IMM)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .rd          (rd),
    .wr          (wr),
    .be          (be),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .rvalid      (rvalid),
    .commit      (commit),
    .commit_done (commit_done),
    .pending     (pending),
    .values_out  (values_out)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] m_shadow [NR];
  logic [DW-1:0] m_live   [NR];
  bit            m_dirty  [NR];
  logic          exp_rvalid, exp_cd;
  logic [DW-1:0] exp_rdata;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] model_values();
    logic [255:0] v = '0;
    for (int i = 0; i < NR; i++) v[DW*i +: DW] = m_live[i];
    return v;
  endfunction

  function automatic logic model_pending();
    for (int i = 0; i < NR; i++) if (m_dirty[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_shadow[i] = '0;
      m_live[i]   = '0;
      m_dirty[i]  = 1'b0;
    end
    exp_rvalid = 1'b0;
    exp_cd     = 1'b0;
    exp_rdata  = '0;
  endtask

  // Reference behaviour of one clock edge: read sees the old shadow, the
  // commit publishes the old shadow, then the write lands.
  task automatic model_edge(input logic e, input logic r, input logic w,
                            input logic [NB-1:0] b, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic c);
    int idx;
    bit in_range;
    logic [DW-1:0] nv;
    idx = int'(a);
    in_range = (idx < NR);
    exp_rvalid = e && r;
    exp_rdata  = (e && r && in_range) ? m_shadow[idx] : '0;
    exp_cd     = c;
    if (c) begin
      for (int i = 0; i < NR; i++) begin
        m_live[i]  = m_shadow[i];
        m_dirty[i] = 1'b0;
      end
    end
    if (e && w && !r && in_range) begin
      nv = m_shadow[idx];
      for (int k = 0; k < NB; k++) if (b[k]) nv[8*k +: 8] = d[8*k +: 8];
      m_shadow[idx] = nv;
      if (IMM[idx]) begin
        m_live[idx]  = nv;
        m_dirty[idx] = 1'b0;
      end else begin
        m_dirty[idx] = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rvalid"}, rvalid, exp_rvalid);
    chk({tag, ".rdata"}, rdata, exp_rdata);
    chk({tag, ".commit_done"}, commit_done, exp_cd);
    chk({tag, ".pending"}, pending, model_pending());
    chk({tag, ".values"}, values_out, model_values());
  endtask

  task automatic cyc(input logic e, input logic r, input logic w,
                     input logic [NB-1:0] b, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic c, input string tag);
    en = e; rd = r; wr = w; be = b; addr = a; wdata = d; commit = c;
    @(posedge clk);
    model_edge(e, r, w, b, a, d, c);
    @(negedge clk);
    en = 1'b0; rd = 1'b0; wr = 1'b0; be = '0; addr = '0; wdata = '0; commit = 1'b0;
    check_all(tag);
  endtask

  initial begin
    logic [255:0] snap;
    logic re, rr, rw, rc;
    logic [NB-1:0] rb;
    logic [AW-1:0] ra;
    logic [DW-1:0] rdd;

    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    reset = 1'b0;
    cyc(0, 0, 0, 2'b00, 5'd0, 16'h0000, 0, "idle0");

    // staged write then commit
    cyc(1, 0, 1, 2'b11, 5'd3, 16'hBEEF, 0, "stage3");
    chk("stage3.slice", values_out[63:48], 16'h0000);
    chk("stage3.pend", pending, 1'b1);
    cyc(0, 0, 0, 2'b00, 5'd0, 16'h0000, 1, "commit3");
    chk("commit3.slice", values_out[63:48], 16'hBEEF);
    chk("commit3.done", commit_done, 1'b1);
    chk("commit3.pend", pending, 1'b0);
    cyc(0, 0, 0, 2'b00, 5'd0, 16'h0000, 0, "after3");
    chk("after3.done", commit_done, 1'b0);

    // byte enables
    cyc(1, 0, 1, 2'b11, 5'd5, 16'h1234, 0, "w5a");
    cyc(0, 0, 0, 2'b00, 5'd0, 16'h0000, 1, "c5a");
    cyc(1, 0, 1, 2'b10, 5'd5, 16'hABCD, 0, "w5b");
    cyc(0, 0, 0, 2'b00, 5'd0, 16'h0000, 1, "c5b");
    chk("be.live", values_out[95:80], 16'hAB34);
    cyc(1, 1, 0, 2'b00, 5'd5, 16'h0000, 0, "rd5");
    chk("rd5.rdata", rdata, 16'hAB34);
    chk("rd5.rvalid", rvalid, 1'b1);
    cyc(0, 0, 0, 2'b00, 5'd0, 16'h0000, 0, "rd5_end");
    chk("rd5_end.rvalid", rvalid, 1'b0);

    // write and commit on the same edge
    cyc(1, 0, 1, 2'b11, 5'd2, 16'h0001, 0, "w2a");
    cyc(0, 0, 0, 2'b00, 5'd0, 16'h0000, 1, "c2a");
    cyc(1, 0, 1, 2'b11, 5'd2, 16'h0002, 1, "wc2");
    chk("wc2.live", values_out[47:32], 16'h0001);
    chk("wc2.pend", pending, 1'b1);
    cyc(0, 0, 0, 2'b00, 5'd0, 16'h0000, 1, "c2b");
    chk("c2b.live", values_out[47:32], 16'h0002);

    // immediate register
    cyc(1, 0, 1, 2'b11, 5'd7, 16'h00FF, 0, "imm7");
    chk("imm7.live", values_out[127:112], 16'h00FF);
    chk("imm7.pend", pending, 1'b0);

    // zero byte enables still mark dirty
    cyc(1, 0, 1, 2'b00, 5'd4, 16'hFFFF, 0, "be0");
    chk("be0.pend", pending, 1'b1);
    chk("be0.live", values_out[79:64], 16'h0000);
    cyc(0, 0, 0, 2'b00, 5'd0, 16'h0000, 1, "be0c");

    // out-of-range and rd+wr
    snap = values_out;
    cyc(1, 0, 1, 2'b11, 5'd16, 16'h9999, 0, "oor_w");
    chk("oor_w.values", values_out, snap);
    chk("oor_w.pend", pending, 1'b0);
    cyc(1, 1, 0, 2'b00, 5'd16, 16'h0000, 0, "oor_r");
    chk("oor_r.rdata", rdata, 16'h0000);
    chk("oor_r.rvalid", rvalid, 1'b1);
    cyc(1, 1, 1, 2'b11, 5'd1, 16'h5555, 0, "rdwr1");
    chk("rdwr1.rvalid", rvalid, 1'b1);
    cyc(1, 1, 0, 2'b00, 5'd1, 16'h0000, 0, "rd1");
    chk("rd1.shadow", rdata, 16'h0000);

    // randomized back-to-back traffic
    for (int n = 0; n < 400; n++) begin
      re  = ($urandom_range(0, 7) != 0);
      rr  = ($urandom_range(0, 2) == 0);
      rw  = ($urandom_range(0, 2) != 0);
      rb  = NB'($urandom);
      ra  = AW'($urandom_range(0, 19));
      rdd = DW'($urandom);
      rc  = ($urandom_range(0, 7) == 0);
      cyc(re, rr, rw, rb, ra, rdd, rc, "rand");
    end
    cyc(0, 0, 0, 2'b00, 5'd0, 16'h0000, 1, "rand_flush");
    for (int i = 0; i < NR; i++) begin
      cyc(1, 1, 0, 2'b00, AW'(i), 16'h0000, 0, "rand_rd");
    end

    // reset in the middle of a read and a commit
    cyc(1, 0, 1, 2'b11, 5'd9, 16'h4321, 0, "pre_rst");
    en = 1'b1; rd = 1'b1; wr = 1'b0; addr = 5'd9; commit = 1'b1;
    @(posedge clk);
    model_edge(1, 1, 0, 2'b00, 5'd9, 16'h0000, 1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("rst_mid");
    en = 1'b1; rd = 1'b0; wr = 1'b1; be = 2'b11; addr = 5'd3; wdata = 16'h7777; commit = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all("rst_hold");
    @(negedge clk);
    en = 1'b0; rd = 1'b0; wr = 1'b0; be = '0; addr = '0; wdata = '0; commit = 1'b0;
    reset = 1'b0;
    cyc(0, 0, 0, 2'b00, 5'd0, 16'h0000, 0, "post_rst0");
    chk("post_rst0.rvalid", rvalid, 1'b0);
    chk("post_rst0.done", commit_done, 1'b0);
    cyc(0, 0, 0, 2'b00, 5'd0, 16'h0000, 0, "post_rst1");
    cyc(1, 1, 0, 2'b00, 5'd9, 16'h0000, 0, "post_rst_rd");
    chk("post_rst_rd.rdata", rdata, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shadow_registers.md
SHADOW_REGISTERS -- requirements
Module: shadow_registers

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, meaning the register address bus width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, meaning the register and bus width; it is a multiple of 8.
REQ-003 SHALL have parameter NUM_REGS, default 64, meaning the register count; NUM_REGS <= 2**ADDR_WIDTH.
REQ-004 SHALL have parameter IMMEDIATE_MASK, width NUM_REGS, default all 0, meaning that bit i=1 makes register i bypass staging.
REQ-005 SHALL have ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  access enable.
- rd  input  1  read request.
- wr  input  1  write request.
- be  input  DATA_WIDTH/8  byte enables.
- addr  input  ADDR_WIDTH  register address.
- wdata  input  DATA_WIDTH  write data.
- rdata  output  DATA_WIDTH  read data.
- rvalid  output  1  read data valid strobe.
- commit  input  1  frame-sync commit strobe.
- commit_done  output  1  commit acknowledge strobe.
- pending  output  1  high while any register is staged but not committed.
- values_out  output  DATA_WIDTH*NUM_REGS  live values; register i occupies bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].

Function
REQ-006 SHALL hold per register a shadow word, a live word and a dirty bit, all updated only on rising clk.
REQ-007 SHALL perform a write when en & wr & ~rd at a rising edge: for each set be[k], update shadow byte k from wdata byte k; leave other bytes unchanged.
REQ-008 SHALL set the dirty bit on a write to a staged register, including a write with be all zero.
REQ-009 SHALL, on a write to an immediate register (IMMEDIATE_MASK[i]=1), update shadow and live together on the same edge and leave dirty clear.
REQ-010 SHALL treat en & rd & wr as a read only; the write is dropped.
REQ-011 SHALL, on a read (en & rd at an edge), drive rdata with the shadow word of addr and pulse rvalid high for exactly the next cycle; latency is 1.
REQ-012 SHALL hold rdata at 0 whenever rvalid is low.
REQ-013 SHALL ignore writes to addr >= NUM_REGS; a read of such an address returns 0 with rvalid.
REQ-014 SHALL, on commit high at an edge, copy shadow to live for every register and clear every dirty bit.
REQ-015 SHALL pulse commit_done for exactly the one cycle after each commit edge, whether or not any register was dirty.
REQ-016 SHALL handle a write and a commit on the same edge as follows:
- live takes the pre-write shadow value.
- the written register's shadow takes the new data.
- its dirty bit ends set, so the new data waits for the next commit.
REQ-017 SHALL handle a commit and a read on the same edge by returning the shadow value.
REQ-018 SHALL drive pending as the combinational OR of all dirty bits.
REQ-019 SHALL drive values_out from live words only; a staged write SHALL never reach values_out before a commit.
REQ-020 SHALL treat back-to-back accesses every cycle as legal, with no stall.

Reset
REQ-021 SHALL, while reset is high, asynchronously clear all shadow words, live words, dirty bits, rdata, rvalid and commit_done to 0.
REQ-022 SHALL abort any read or commit in flight at reset assertion; no rvalid or commit_done pulse follows reset deassertion.
REQ-023 SHALL ignore en, rd, wr and commit while reset is high.

Structure
REQ-024 SHALL place default widths, NUM_REGS and the byte-count helper constant (DATA_WIDTH/8) in the shared package cc_regs_pkg.
REQ-025 SHALL implement each register as the sub-module shadow_register_cell, which holds shadow, live and dirty with inputs write-enable, byte-enable, immediate and commit.
REQ-026 SHALL keep the read mux and the rvalid/commit_done strobes in the top level.

Verification
REQ-027 SHALL cover staged write, with DATA_WIDTH=16:
- stimulus: write 0xBEEF to addr 3 with be=11.
- response: values_out[63:48] stays 0x0000 and pending=1.
- stimulus: commit.
- response: the slice becomes 0xBEEF on the next edge, pending=0, commit_done is high for 1 cycle.
REQ-028 SHALL cover byte enables:
- stimulus: commit 0x1234 to addr 5, then write 0xABCD with be=10, then commit.
- response: live value is 0xAB34.
- stimulus: read addr 5.
- response: rdata=0xAB34 with rvalid one cycle after the read edge.
REQ-029 SHALL cover write and commit on the same edge:
- stimulus: commit 0x0001 to addr 2; then write 0x0002 to addr 2 on the same edge as a commit.
- response: live=0x0001 and pending=1.
- stimulus: a second commit.
- response: live=0x0002.
REQ-030 SHALL cover an immediate register: with IMMEDIATE_MASK bit 7 set, write 0x00FF to addr 7 -> live=0x00FF on the next edge, pending stays 0.
REQ-031 SHALL cover out-of-range access and rd+wr:
- stimulus: write to addr NUM_REGS.
- response: no register changes.
- stimulus: a read of the same address.
- response: rdata=0 with rvalid.
- stimulus: en & rd & wr to addr 1.
- response: a read occurs and shadow[1] is unchanged.
REQ-032 SHALL cover reset mid-operation:
- stimulus: assert reset between a commit edge and the commit_done cycle, and between a read edge and the rvalid cycle.
- response: all outputs 0, no commit_done pulse and no rvalid pulse after release.
